// File: rtl/tank_pkg.sv
// Shared types, default screen geometry and the coordinate clamp used by
// the tank position scheduler.
package tank_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    LOCK   = 2'd1,
    COMMIT = 2'd2
  } sched_state_t;

  localparam coord_t H_ACTIVE_DEF = 10'd640;
  localparam coord_t V_ACTIVE_DEF = 10'd480;
  localparam coord_t OBJ_SIZE_DEF = 10'd4;

  // Unsigned clamp: an underflowed mover (e.g. 10'h3FF) lands on the high bound.
  function automatic coord_t clampCoord(input coord_t value, input coord_t lo, input coord_t hi);
    coord_t result;
    if (value < lo) begin
      result = lo;
    end else if (value > hi) begin
      result = hi;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grants at most one requester per cycle and
// flips its pointer after every grant, so contention alternates.
module rr_arbiter2 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic r_ptr;

  // A lone requester always wins; on contention the pointer picks the winner.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Toggle the pointer each time a grant is issued.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_ptr <= 1'b0;
    end else if (|gnt) begin
      r_ptr <= ~r_ptr;
    end
  end

endmodule

// File: rtl/frame_obj_scheduler.sv
// Frame-synchronous tank position scheduler. The two movement controllers
// write clamped positions into shadow registers through a round-robin
// arbiter; the shadows are copied to the active (displayed) positions once
// per vsync, so a frame never shows a half-updated pair.
// Optional build macro: PRIO_ROTATE_EN -- when defined, the overlap draw
// priority alternates every frame; otherwise tank 0 is always on top.
module frame_obj_scheduler
  import tank_pkg::*;
#(
  parameter coord_t OBJ_SIZE = OBJ_SIZE_DEF,
  parameter coord_t H_ACTIVE = H_ACTIVE_DEF,
  parameter coord_t V_ACTIVE = V_ACTIVE_DEF,
  parameter coord_t INIT_X0  = 10'd160,
  parameter coord_t INIT_Y0  = 10'd240,
  parameter coord_t INIT_X1  = 10'd480,
  parameter coord_t INIT_Y1  = 10'd240
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic [1:0]       upd_valid,
  input  coord_t [1:0]     upd_X,
  input  coord_t [1:0]     upd_Y,
  output logic [1:0]       upd_ready,
  output coord_t           BallX1,
  output coord_t           BallY1,
  output coord_t           BallX2,
  output coord_t           BallY2,
  output logic             prio_sel,
  output logic [15:0]      frame_cnt
);

  localparam coord_t X_MAX = coord_t'(H_ACTIVE - 10'd1 - OBJ_SIZE);
  localparam coord_t Y_MAX = coord_t'(V_ACTIVE - 10'd1 - OBJ_SIZE);

  logic         r_sync1;
  logic         r_sync2;
  logic         r_syncPrev;
  logic         w_framePulse;
  sched_state_t r_state;
  coord_t       r_shadowX [2];
  coord_t       r_shadowY [2];
  coord_t       r_activeX [2];
  coord_t       r_activeY [2];
  logic [15:0]  r_frameCnt;
  logic [1:0]   w_req;
  logic [1:0]   w_gnt;

  // Bring vsync into the Clk domain and remember the previous level for edge detection.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_syncPrev <= 1'b0;
    end else begin
      r_sync1    <= frame_clk;
      r_sync2    <= r_sync1;
      r_syncPrev <= r_sync2;
    end
  end

  assign w_framePulse = r_sync2 & ~r_syncPrev;

  // Requests are only eligible while accepting, and never while reset is held.
  assign w_req     = upd_valid & {2{(r_state == ACCEPT) && !Reset}};
  assign upd_ready = w_gnt;

  rr_arbiter2 u_arb (
    .Clk   (Clk),
    .Reset (Reset),
    .req   (w_req),
    .gnt   (w_gnt)
  );

  // The granted requester's clamped position overwrites its shadow; later writes win.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_shadowX[0] <= INIT_X0;
      r_shadowY[0] <= INIT_Y0;
      r_shadowX[1] <= INIT_X1;
      r_shadowY[1] <= INIT_Y1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_gnt[i]) begin
          r_shadowX[i] <= clampCoord(upd_X[i], OBJ_SIZE, X_MAX);
          r_shadowY[i] <= clampCoord(upd_Y[i], OBJ_SIZE, Y_MAX);
        end
      end
    end
  end

`ifdef PRIO_ROTATE_EN
  logic r_prio;
  assign prio_sel = r_prio;
`else
  assign prio_sel = 1'b0;
`endif

  // Scheduler: accept writes, freeze one cycle on vsync, then commit shadows to the display.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= ACCEPT;
      r_activeX[0] <= INIT_X0;
      r_activeY[0] <= INIT_Y0;
      r_activeX[1] <= INIT_X1;
      r_activeY[1] <= INIT_Y1;
      r_frameCnt   <= 16'd0;
`ifdef PRIO_ROTATE_EN
      r_prio       <= 1'b0;
`endif
    end else begin
      case (r_state)
        ACCEPT: begin
          if (w_framePulse) begin
            r_state <= LOCK;
          end
        end
        LOCK: begin
          r_state <= COMMIT;
        end
        COMMIT: begin
          r_activeX[0] <= r_shadowX[0];
          r_activeY[0] <= r_shadowY[0];
          r_activeX[1] <= r_shadowX[1];
          r_activeY[1] <= r_shadowY[1];
          r_frameCnt   <= r_frameCnt + 16'd1;
`ifdef PRIO_ROTATE_EN
          r_prio       <= ~r_prio;
`endif
          r_state      <= ACCEPT;
        end
        default: begin
          r_state <= ACCEPT;
        end
      endcase
    end
  end

  assign BallX1    = r_activeX[0];
  assign BallY1    = r_activeY[0];
  assign BallX2    = r_activeX[1];
  assign BallY2    = r_activeY[1];
  assign frame_cnt = r_frameCnt;

endmodule
